// File: rtl/tff_counter_ctrl.sv
// tff_counter_ctrl: sequences a bank of WIDTH T flip-flops as a bounded
// synchronous up/down counter with start / stop / pause control.
//
// The bank state updates as q <= q ^ t_vec, where t_vec is the per-bit
// toggle vector of a binary up or down step.
//
// Optional feature: define TFF_CTRL_AUTORELOAD_EN to make a run reload and
// continue at the terminal count. The result is a periodic divide-by-(limit+1)
// with done as the tick. Only stop or reset then ends the run.
module tff_counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    input  logic             pause,
    input  logic             stop,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t_vec,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] lim_r;
    logic             dir_r;
    logic             done_r;

    logic [WIDTH-1:0] target_s;
    logic             at_target_s;
    logic             step_s;
    logic [WIDTH-1:0] t_vec_s;
    logic             carry_s;

    // Terminal value of the latched run and the compare against the bank.
    always_comb begin
        target_s    = {WIDTH{1'b0}};
        if (dir_r) begin
            target_s = lim_r;
        end else begin
            target_s = {WIDTH{1'b0}};
        end
        at_target_s = (q_r == target_s);
    end

    // Toggle vector: bit i flips when all lower bits are 1 (up) or 0 (down).
    // It is forced to zero on any cycle where the bank will not step.
    always_comb begin
        t_vec_s = {WIDTH{1'b0}};
        carry_s = 1'b1;
        step_s  = (state_r == ST_RUN) && !stop && !at_target_s && !pause;
        if (step_s) begin
            for (int i = 0; i < WIDTH; i++) begin
                t_vec_s[i] = carry_s;
                if (dir_r) begin
                    carry_s = carry_s & q_r[i];
                end else begin
                    carry_s = carry_s & ~q_r[i];
                end
            end
        end else begin
            t_vec_s = {WIDTH{1'b0}};
        end
    end

    // Run sequencer: state, T-FF bank, latched run parameters and done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            q_r     <= {WIDTH{1'b0}};
            lim_r   <= {WIDTH{1'b0}};
            dir_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        dir_r   <= dir;
                        lim_r   <= limit;
                        q_r     <= dir ? {WIDTH{1'b0}} : limit;
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_r <= ST_IDLE;
                    end else if (at_target_s) begin
                        done_r  <= 1'b1;
`ifdef TFF_CTRL_AUTORELOAD_EN
                        q_r     <= dir_r ? {WIDTH{1'b0}} : lim_r;
                        state_r <= ST_RUN;
`else
                        state_r <= ST_IDLE;
`endif
                    end else if (pause) begin
                        state_r <= ST_PAUSE;
                    end else begin
                        q_r <= q_r ^ t_vec_s;
                    end
                end
                ST_PAUSE: begin
                    if (stop) begin
                        state_r <= ST_IDLE;
                    end else if (!pause) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_PAUSE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign q     = q_r;
    assign t_vec = t_vec_s;
    assign busy  = (state_r != ST_IDLE);
    assign tc    = (state_r != ST_IDLE) && at_target_s;
    assign done  = done_r;

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Self-checking bench for tff_counter_ctrl: directed scenarios followed by
// random start/dir/limit/pause/stop traffic. Everything is compared against
// an integer-arithmetic reference model of the counter run.
module tb_tff_counter_ctrl;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         dir;
    logic [W-1:0] limit;
    logic         pause;
    logic         stop;
    logic [W-1:0] q;
    logic [W-1:0] t_vec;
    logic         busy;
    logic         tc;
    logic         done;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: plain integers and flags.
    bit m_running = 1'b0;
    bit m_paused  = 1'b0;
    bit m_done    = 1'b0;
    int m_cnt     = 0;
    int m_up      = 0;
    int m_lim     = 0;

    tff_counter_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .dir   (dir),
        .limit (limit),
        .pause (pause),
        .stop  (stop),
        .q     (q),
        .t_vec (t_vec),
        .busy  (busy),
        .tc    (tc),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_target();
        return (m_up != 0) ? m_lim : 0;
    endfunction

    task automatic model_reset();
        m_running = 1'b0;
        m_paused  = 1'b0;
        m_done    = 1'b0;
        m_cnt     = 0;
        m_up      = 0;
        m_lim     = 0;
    endtask

    // Compare all outputs against the model for the inputs now applied.
    task automatic check_outputs();
        int  tv_e;
        bit  busy_e;
        bit  tc_e;
        busy_e = m_running || m_paused;
        tc_e   = busy_e && (m_cnt == m_target());
        tv_e   = 0;
        if (m_running && !stop && !pause && (m_cnt != m_target())) begin
            if (m_up != 0) tv_e = (m_cnt ^ (m_cnt + 1)) & MASK;
            else           tv_e = (m_cnt ^ (m_cnt - 1)) & MASK;
        end
        check_val("q",     32'(q),     32'(m_cnt));
        check_val("busy",  32'(busy),  32'(busy_e));
        check_val("tc",    32'(tc),    32'(tc_e));
        check_val("done",  32'(done),  32'(m_done));
        check_val("t_vec", 32'(t_vec), 32'(tv_e));
    endtask

    // Advance the model by one rising edge using the currently applied inputs.
    task automatic model_step();
        bit was_running = m_running;
        bit was_paused  = m_paused;
        m_done = 1'b0;
        if (!was_running && !was_paused) begin
            if (start) begin
                m_up      = int'(dir);
                m_lim     = int'(limit);
                m_cnt     = dir ? 0 : int'(limit);
                m_running = 1'b1;
            end
        end else if (was_running) begin
            if (stop) begin
                m_running = 1'b0;
            end else if (m_cnt == m_target()) begin
                m_done = 1'b1;
`ifdef TFF_CTRL_AUTORELOAD_EN
                m_cnt = (m_up != 0) ? 0 : m_lim;
`else
                m_running = 1'b0;
`endif
            end else if (pause) begin
                m_running = 1'b0;
                m_paused  = 1'b1;
            end else begin
                m_cnt = (m_up != 0) ? m_cnt + 1 : m_cnt - 1;
            end
        end else begin
            if (stop) begin
                m_paused = 1'b0;
            end else if (!pause) begin
                m_paused  = 1'b0;
                m_running = 1'b1;
            end
        end
    endtask

    // One clock: drive inputs at the falling edge, check, then step on the rising edge.
    task automatic cycle(input bit s, input bit d, input int l, input bit p, input bit sp);
        @(negedge clk);
        start = s;
        dir   = d;
        limit = W'(l);
        pause = p;
        stop  = sp;
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'($urandom), int'($urandom_range(0, MASK)), 1'b0, 1'b0);
        end
    endtask

    initial begin
        int n_edges;
        reset = 1'b0;
        start = 1'b0;
        dir   = 1'b0;
        limit = '0;
        pause = 1'b0;
        stop  = 1'b0;
        model_reset();
        #12;
        check_val("rst_q",    32'(q),     32'd0);
        check_val("rst_busy", 32'(busy),  32'd0);
        check_val("rst_tv",   32'(t_vec), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle_cycles(2);

        // Up count to 3: literal checks on top of the model.
        cycle(1'b1, 1'b1, 3, 1'b0, 1'b0);
        #1 check_val("up_q0", 32'(q), 32'd0);
        cycle(1'b0, 1'b0, 9, 1'b0, 1'b0);
        #1 check_val("up_tv_1to2", 32'(t_vec), 32'h3);
        idle_cycles(5);

        // Down count from 9: toggle 8->7 and edge count to done.
        cycle(1'b1, 1'b0, 9, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 2, 1'b0, 1'b0);
        #1 check_val("dn_tv_8to7", 32'(t_vec), 32'hF);
        n_edges = 2;
        while (done !== 1'b1 && n_edges < 20) begin
            cycle(1'b0, 1'($urandom), 0, 1'b0, 1'b0);
            n_edges++;
            #1;
        end
        check_val("dn_edges_to_done", 32'(n_edges), 32'd11);
        idle_cycles(2);

        // Pause at 3, resume, start while busy, stop at 5.
        cycle(1'b1, 1'b1, 7, 1'b0, 1'b0);
        idle_cycles(3);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
        #1 check_val("pause_q", 32'(q), 32'd3);
        cycle(1'b0, 1'b0, 0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 0, 1'b0, 1'b0);
        #1 check_val("resume_q", 32'(q), 32'd4);
        cycle(1'b1, 1'b0, 2, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);
        #1 check_val("stop_q", 32'(q), 32'd5);
        idle_cycles(2);

        // Asynchronous reset mid-run at q=5.
        cycle(1'b1, 1'b1, 7, 1'b0, 1'b0);
        idle_cycles(5);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_val("async_rst_q",    32'(q),    32'd0);
        check_val("async_rst_busy", 32'(busy), 32'd0);
        check_val("async_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle_cycles(2);

        // Edge cases: limit 0 both directions, limit 15 up, stop at target.
        cycle(1'b1, 1'b1, 0, 1'b0, 1'b0);
        idle_cycles(3);
        cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
        idle_cycles(3);
        cycle(1'b1, 1'b1, 15, 1'b0, 1'b0);
        idle_cycles(18);
`ifndef TFF_CTRL_AUTORELOAD_EN
        #1 check_val("lim15_no_wrap", 32'(q), 32'd15);
`endif
        cycle(1'b1, 1'b1, 2, 1'b0, 1'b0);
        idle_cycles(2);
        cycle(1'b0, 1'b0, 0, 1'b0, 1'b1);
        #1 check_val("stop_at_tc_done", 32'(done), 32'd0);
        idle_cycles(2);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 3) == 0), 1'($urandom), int'($urandom_range(0, MASK)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
